// File: rtl/coarse_counter_multi.sv
// rtl/coarse_counter_multi.sv - multi-channel coarse start->stop interval counter for the TDC
//
// Purpose: a free-running modulo-MODULUS counter timestamps one start edge and up to
// N_STOP stop edges per measurement window and reports per-channel intervals (in
// clock periods) through a valid/ready result port.
//
// Ports:
//   clk        - single clock, all logic on posedge
//   reset      - synchronous, active-high
//   start      - start level (synchronous to clk)
//   stop       - per-channel stop levels (synchronous to clk)
//   data       - intervals, channel k in data[k*WIDTH +: WIDTH]
//   hit_mask   - channels that saw a stop in the window
//   timeout    - window closed by TIMEOUT rather than by all channels hitting
//   overrun    - start edge seen while busy, sticky until the result handshake
//   data_valid - result available
//   data_ready - consumer accepts result on data_valid & data_ready
//   busy       - high whenever not IDLE
module coarse_counter_multi #(
  parameter int WIDTH   = 16,
  parameter int MODULUS = 60000,
  parameter int N_STOP  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_STOP-1:0]         stop,
  output logic [N_STOP*WIDTH-1:0]   data,
  output logic [N_STOP-1:0]         hit_mask,
  output logic                      timeout,
  output logic                      overrun,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEASURE,
    S_CALC,
    S_DONE,
    S_REARM
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] EL_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      start_prev_q, start_prev_d;
  logic [N_STOP-1:0]         stop_prev_q, stop_prev_d;
  logic [WIDTH-1:0]          start_ts_q, start_ts_d;
  logic [WIDTH-1:0]          ts_q [N_STOP];
  logic [WIDTH-1:0]          ts_d [N_STOP];
  logic [N_STOP-1:0]         hit_q, hit_d;
  logic [WIDTH-1:0]          elapsed_q, elapsed_d;
  logic [N_STOP*WIDTH-1:0]   data_q, data_d;
  logic [N_STOP-1:0]         hit_mask_q, hit_mask_d;
  logic                      timeout_q, timeout_d;
  logic                      overrun_q, overrun_d;
  logic                      data_valid_q, data_valid_d;
  logic                      start_ev;
  logic [N_STOP-1:0]         stop_ev;

  // Interval modulo the counter period; a stop that precedes start numerically
  // happened after a counter wrap.
  function automatic logic [WIDTH-1:0] interval(input logic [WIDTH-1:0] ts,
                                                input logic [WIDTH-1:0] st);
    logic [WIDTH:0] diff;
    if (ts >= st) diff = {1'b0, ts} - {1'b0, st};
    else          diff = MOD_EXT - {1'b0, st} + {1'b0, ts};
    return diff[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    start_ts_d   = start_ts_q;
    hit_d        = hit_q;
    elapsed_d    = elapsed_q;
    data_d       = data_q;
    hit_mask_d   = hit_mask_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    data_valid_d = data_valid_q;
    for (int k = 0; k < N_STOP; k++) ts_d[k] = ts_q[k];

    start_ev     = start & ~start_prev_q;
    stop_ev      = stop & ~stop_prev_q;
    start_prev_d = start;
    stop_prev_d  = stop;
    cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + WIDTH'(1);

    if (start_ev && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          start_ts_d = cnt_q;
          elapsed_d  = '0;
          // A stop on the start edge belongs to this window (interval 0).
          hit_d      = stop_ev;
          for (int k = 0; k < N_STOP; k++) ts_d[k] = stop_ev[k] ? cnt_q : '0;
          state_d    = S_MEASURE;
        end
      end
      S_MEASURE: begin
        elapsed_d = elapsed_q + WIDTH'(1);
        for (int k = 0; k < N_STOP; k++) begin
          if (stop_ev[k] && !hit_q[k]) begin
            hit_d[k] = 1'b1;
            ts_d[k]  = cnt_q;
          end
        end
        // Stops on the closing edge count, so completion is judged on hit_d.
        if (&hit_d) begin
          timeout_d = 1'b0;
          state_d   = S_CALC;
        end else if (elapsed_q == EL_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        for (int k = 0; k < N_STOP; k++)
          data_d[k*WIDTH +: WIDTH] = hit_q[k] ? interval(ts_q[k], start_ts_q) : '0;
        hit_mask_d   = hit_q;
        data_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (data_ready) begin
          data_valid_d = 1'b0;
          overrun_d    = 1'b0;
          state_d      = S_REARM;
        end
      end
      S_REARM: begin
        if (!start && stop == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= '1;
      start_ts_q   <= '0;
      hit_q        <= '0;
      elapsed_q    <= '0;
      data_q       <= '0;
      hit_mask_q   <= '0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      data_valid_q <= 1'b0;
      for (int k = 0; k < N_STOP; k++) ts_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      start_ts_q   <= start_ts_d;
      hit_q        <= hit_d;
      elapsed_q    <= elapsed_d;
      data_q       <= data_d;
      hit_mask_q   <= hit_mask_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      data_valid_q <= data_valid_d;
      for (int k = 0; k < N_STOP; k++) ts_q[k] <= ts_d[k];
    end
  end

  assign data       = data_q;
  assign hit_mask   = hit_mask_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_coarse_counter_multi.sv
// tb/tb_coarse_counter_multi.sv - directed self-checking bench for coarse_counter_multi
module tb_coarse_counter_multi;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int MOD = 60000;
  localparam int TO  = 1000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   stop = '0;
  logic           data_ready = 1'b0;
  logic [N*W-1:0] data;
  logic [N-1:0]   hit_mask;
  logic           timeout, overrun, data_valid, busy;

  int ncmp = 0;
  int nerr = 0;
  int tb_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int lat = 0;

  coarse_counter_multi #(.WIDTH(W), .MODULUS(MOD), .N_STOP(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .data(data),
    .hit_mask(hit_mask), .timeout(timeout), .overrun(overrun),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference counter: value the DUT will sample at the next posedge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == MOD - 1) ? 0 : tb_cnt + 1;
  end

  // Start pulse when counter == st, stop k pulse when counter == sk (-1 = none).
  task automatic sched(input int st, input int s0, input int s1, input int s2,
                       input int s3, input int len);
    int guard = 0;
    while (tb_cnt != st && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    ncmp++;
    if (tb_cnt != st) begin
      nerr++;
      $display("FAIL sched_reach: got cnt %0d expected %0d", tb_cnt, st);
    end
    for (int i = 0; i < len; i++) begin
      start   = (i == 0);
      stop[0] = (tb_cnt == s0);
      stop[1] = (tb_cnt == s1);
      stop[2] = (tb_cnt == s2);
      stop[3] = (tb_cnt == s3);
      if (i == 0) start_cyc = cyc + 1;
      @(negedge clk);
    end
    start = 1'b0;
    stop  = '0;
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!data_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    lat = cyc - start_cyc;
    ncmp++;
    if (data_valid !== 1'b1) begin
      nerr++;
      $display("FAIL wait_valid: got data_valid %b expected 1", data_valid);
    end
  endtask

  task automatic check_result(input string nm, input logic [N*W-1:0] exp_data,
                              input logic [N-1:0] exp_hit, input logic exp_to, input int exp_lat);
    ncmp++;
    if (data !== exp_data) begin
      nerr++;
      $display("FAIL %s_data: got %h expected %h", nm, data, exp_data);
    end
    ncmp++;
    if (hit_mask !== exp_hit) begin
      nerr++;
      $display("FAIL %s_hit: got %b expected %b", nm, hit_mask, exp_hit);
    end
    ncmp++;
    if (timeout !== exp_to) begin
      nerr++;
      $display("FAIL %s_timeout: got %b expected %b", nm, timeout, exp_to);
    end
    if (exp_lat >= 0) begin
      ncmp++;
      if (lat != exp_lat) begin
        nerr++;
        $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat);
      end
    end
  endtask

  // Handshake, then REARM for one cycle, then IDLE.
  task automatic accept(input string nm);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    ncmp++;
    if ({data_valid, overrun, busy} !== 3'b001) begin
      nerr++;
      $display("FAIL %s_accept: got valid/overrun/busy %b expected 001", nm, {data_valid, overrun, busy});
    end
    @(negedge clk);
    ncmp++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_rearm: got busy %b expected 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    stop  = '1;
    repeat (3) @(negedge clk);
    ncmp++;
    if ({data, hit_mask, timeout, overrun, data_valid, busy} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b/%b/%b expected all 0",
               data, hit_mask, timeout, overrun, data_valid, busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_held_start: got busy %b expected 0", busy);
    end
    start = 1'b0;
    stop  = '0;
    @(negedge clk);
  endtask

  task automatic test_four_channels();
    // Last stop lands on the closing edge: all hits complete, so no timeout.
    sched(100, 350, 400, 1100, 101, 1002);
    wait_valid();
    check_result("four_ch", {16'd1, 16'd1000, 16'd300, 16'd250}, 4'b1111, 1'b0, 1001);
    accept("four_ch");
  endtask

  task automatic test_timeout();
    // ch2 on the closing edge is captured; ch1 one edge later is ignored.
    sched(2000, 2005, 3001, 3000, -1, 1002);
    wait_valid();
    check_result("timeout", {16'd0, 16'd1000, 16'd0, 16'd5}, 4'b0101, 1'b1, 1001);
    accept("timeout");
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] exp_data;
    exp_data = {16'd5, 16'd4, 16'd3, 16'd2};
    sched(4000, 4002, 4003, 4004, 4005, 6);
    wait_valid();
    check_result("bp", exp_data, 4'b1111, 1'b0, 6);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clk);
      ncmp++;
      if (data !== exp_data || data_valid !== 1'b1 || hit_mask !== 4'b1111) begin
        nerr++;
        $display("FAIL bp_stable_%0d: got %h/%b/%b expected %h/1/1111",
                 i, data, data_valid, hit_mask, exp_data);
      end
    end
    start = 1'b0;
    ncmp++;
    if (overrun !== 1'b1) begin
      nerr++;
      $display("FAIL bp_overrun: got %b expected 1", overrun);
    end
    accept("bp");
  endtask

  task automatic test_same_edge();
    sched(5000, 5000, -1, -1, -1, 1);
    @(negedge clk);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    wait_valid();
    check_result("same_edge", '0, 4'b0001, 1'b1, 1001);
    accept("same_edge");
  endtask

  task automatic test_reset_midrun();
    sched(7000, -1, -1, -1, -1, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ncmp++;
    if ({data, hit_mask, timeout, overrun, data_valid, busy} !== '0) begin
      nerr++;
      $display("FAIL midrun_reset: got %h/%b/%b/%b/%b/%b expected all 0",
               data, hit_mask, timeout, overrun, data_valid, busy);
    end
    sched(50, -1, 77, -1, -1, 28);
    wait_valid();
    check_result("after_reset", {16'd0, 16'd0, 16'd27, 16'd0}, 4'b0010, 1'b1, 1001);
    accept("after_reset");
  endtask

  task automatic test_wrap();
    sched(59990, 20, -1, -1, -1, 31);
    wait_valid();
    check_result("wrap", {16'd0, 16'd0, 16'd0, 16'd30}, 4'b0001, 1'b1, 1001);
    accept("wrap");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_four_channels();
    test_timeout();
    test_backpressure();
    test_same_edge();
    test_reset_midrun();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
